// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The FSM state enum is also carried on the interface for debug visibility.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STOP  = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES = 128;
    localparam logic [31:0] HALT_WORD  = 32'h0000_0000;

    // A fetch address is usable only if word-aligned and the whole word fits in memory.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] imem_bytes);
        return (pc[1:0] == 2'b00) && (pc <= imem_bytes - 32'd4);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus between the fetch sequencer, instruction memory, branch unit and decode.
// Handshake: an entry transfers on every cycle where out_valid && out_ready; out_* stay stable while out_valid && !out_ready.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic [31:0]  imem_addr;
    logic [31:0]  imem_rdata;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pc;
    logic [31:0]  out_instr;
    logic         halted;
    logic         fault;
    fetch_state_e state;

    modport master (
        output imem_addr, out_valid, out_pc, out_instr, halted, fault, state,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_pc, out_instr, halted, fault, state,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of {pc, instr} pairs; flush wins over push and pop.
module fetch_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads imem combinationally and queues
// {pc, instr} pairs towards decode, with redirect, halt-word stop and fault detection.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = fetch_pkg::RESET_PC,
    parameter int unsigned IMEM_BYTES = fetch_pkg::IMEM_BYTES,
    parameter logic [31:0] HALT_WORD  = fetch_pkg::HALT_WORD
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);
    import fetch_pkg::*;

    localparam logic [31:0] IMEM_SIZE = 32'(IMEM_BYTES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         push, pop, flush;
    logic         full, empty;
    logic [1:0]   count;
    logic [63:0]  head;
    logic         pc_ok, tgt_ok, is_halt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        pc_ok   = pc_legal(pc_q, IMEM_SIZE);
        tgt_ok  = pc_legal(bus.redirect_pc, IMEM_SIZE);
        is_halt = (bus.imem_rdata == HALT_WORD);
        pop     = !empty && (state_q != FAULT) && bus.out_ready;

        if (state_q != FAULT && bus.redirect_valid) begin
            // Redirect outranks everything else and discards whatever was queued.
            flush = 1'b1;
            if (tgt_ok) begin
                pc_d    = bus.redirect_pc;
                state_d = RUN;
            end else begin
                state_d = FAULT;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!pc_ok) begin
                        state_d = FAULT;
                        flush   = 1'b1;
                    end else if (is_halt) begin
                        state_d = STOP;
                    end else if (!full || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                STOP: begin
                    if (empty) state_d = HALT;
                end
                HALT:    state_d = HALT;
                FAULT:   state_d = FAULT;
                default: state_d = FAULT;
            endcase
        end
    end

    fetch_fifo #(.W(64)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data ({pc_q, bus.imem_rdata}),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = !empty && (state_q != FAULT);
    assign bus.out_pc    = head[63:32];
    assign bus.out_instr = head[31:0];
    assign bus.halted    = (state_q == HALT);
    assign bus.fault     = (state_q == FAULT);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: lab-2 program, back-pressure, redirects, halt and fault.
// A second instance with a non-zero halt word covers the sequential overrun into 0x80.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if bus1 ();
    fetch_ctrl_if bus2 ();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    fetch_ctrl #(.HALT_WORD(32'hFFFF_FFFF)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    logic [31:0] imem [32];
    logic [31:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    int pops2;
    logic [31:0] last_pc2;

    assign bus1.imem_rdata = (bus1.imem_addr < 32'd128) ? imem[bus1.imem_addr[6:2]] : 32'h0;
    assign bus2.imem_rdata = (bus2.imem_addr < 32'd128) ? imem[bus2.imem_addr[6:2]] : 32'h0;
    assign bus2.out_ready      = 1'b1;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 32'h0;

    always @(negedge clk) begin
        if (rst) begin
            pops2    <= 0;
            last_pc2 <= 32'h0;
        end else if (bus2.out_valid) begin
            pops2    <= pops2 + 1;
            last_pc2 <= bus2.out_pc;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus1.redirect_valid = 1'b1;
        bus1.redirect_pc    = target;
        step();
        bus1.redirect_valid = 1'b0;
    endtask

    task automatic reset_and_release(input logic ready);
        rst = 1'b1;
        bus1.redirect_valid = 1'b0;
        bus1.out_ready      = ready;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) imem[i] = 32'h0;
        imem[0]  = 32'hff600293; imem[1]  = 32'h00528333; imem[2]  = 32'h00100393;
        imem[3]  = 32'h00730333; imem[4]  = 32'hfff28293; imem[5]  = 32'hfe029ce3;
        imem[6]  = 32'h00000e13; imem[7]  = 32'h01c30e33; imem[8]  = 32'h00030eb3;
        imem[9]  = 32'h01d31463; imem[10] = 32'h00138393; imem[11] = 32'h000003b3;
        imem[12] = 32'h00538393; imem[13] = 32'h00628313; imem[14] = 32'h40530333;
        imem[15] = 32'h00131313; imem[16] = 32'h0062c2b3; imem[17] = 32'h007383b3;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc    = 32'h0;
        bus1.out_ready      = 1'b1;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_valid",  {31'h0, bus1.out_valid}, 32'h0);
        check("rst_pc",     bus1.out_pc, 32'h0);
        check("rst_instr",  bus1.out_instr, 32'h0);
        check("rst_halted", {31'h0, bus1.halted}, 32'h0);
        check("rst_fault",  {31'h0, bus1.fault}, 32'h0);
        check("rst_addr",   bus1.imem_addr, RESET_PC);
        check("rst_state",  {30'h0, bus1.state}, {30'h0, RUN});

        // Straight-line program, then halt on the zero padding word
        rst = 1'b0;
        for (int i = 0; i < 18; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 18; i++) begin
            logic [31:0] e;
            step();
            e = exp_q.pop_front();
            check("seq_valid", {31'h0, bus1.out_valid}, 32'h1);
            check("seq_pc",    bus1.out_pc, e);
            check("seq_instr", bus1.out_instr, imem[i]);
        end
        step();
        check("stop_valid",  {31'h0, bus1.out_valid}, 32'h0);
        check("stop_halted", {31'h0, bus1.halted}, 32'h0);
        check("stop_state",  {30'h0, bus1.state}, {30'h0, STOP});
        check("stop_addr",   bus1.imem_addr, 32'h48);
        step();
        check("halt_halted", {31'h0, bus1.halted}, 32'h1);
        check("halt_fault",  {31'h0, bus1.fault}, 32'h0);

        // Back-pressure: FIFO fills with 0x00/0x04, PC parks at 0x08
        reset_and_release(1'b0);
        check("bp_rst_halted", {31'h0, bus1.halted}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", {31'h0, bus1.out_valid}, 32'h1);
            check("bp_pc",    bus1.out_pc, 32'h0);
        end
        check("bp_instr", bus1.out_instr, 32'hff600293);
        check("bp_addr",  bus1.imem_addr, 32'h08);
        bus1.out_ready = 1'b1;
        exp_q = {32'h00, 32'h04, 32'h08};
        while (exp_q.size() > 0) begin
            check("bp_drain_valid", {31'h0, bus1.out_valid}, 32'h1);
            check("bp_drain_pc",    bus1.out_pc, exp_q.pop_front());
            step();
        end

        // Redirect while the FIFO is full
        reset_and_release(1'b0);
        step();
        step();
        check("rd_full_addr", bus1.imem_addr, 32'h08);
        redirect(32'h20);
        check("rd_flush_valid", {31'h0, bus1.out_valid}, 32'h0);
        check("rd_addr",        bus1.imem_addr, 32'h20);
        bus1.out_ready = 1'b1;
        step();
        check("rd_valid0", {31'h0, bus1.out_valid}, 32'h1);
        check("rd_pc0",    bus1.out_pc, 32'h20);
        check("rd_instr0", bus1.out_instr, 32'h00030eb3);
        step();
        check("rd_pc1",    bus1.out_pc, 32'h24);
        check("rd_instr1", bus1.out_instr, 32'h01d31463);

        // Run to halt, then redirect out of HALT
        for (int i = 0; i < 40 && !bus1.halted; i++) step();
        check("wait_halted", {31'h0, bus1.halted}, 32'h1);
        redirect(32'h2C);
        check("unhalt_halted", {31'h0, bus1.halted}, 32'h0);
        check("unhalt_valid",  {31'h0, bus1.out_valid}, 32'h0);
        for (int k = 0; k < 7; k++) begin
            step();
            check("rehalt_pc",    bus1.out_pc, 32'h2C + 32'(4 * k));
            check("rehalt_instr", bus1.out_instr, imem[11 + k]);
        end
        step();
        check("rehalt_stop", {31'h0, bus1.halted}, 32'h0);
        step();
        check("rehalt_halted", {31'h0, bus1.halted}, 32'h1);

        // Misaligned redirect faults; FAULT ignores later redirects
        redirect(32'h22);
        check("mis_fault", {31'h0, bus1.fault}, 32'h1);
        check("mis_valid", {31'h0, bus1.out_valid}, 32'h0);
        check("mis_state", {30'h0, bus1.state}, {30'h0, FAULT});
        redirect(32'h00);
        check("mis_ignore_fault", {31'h0, bus1.fault}, 32'h1);
        check("mis_ignore_addr",  bus1.imem_addr, 32'h48);
        check("mis_ignore_valid", {31'h0, bus1.out_valid}, 32'h0);
        rst = 1'b1;
        step();
        check("mid_rst_fault", {31'h0, bus1.fault}, 32'h0);
        check("mid_rst_valid", {31'h0, bus1.out_valid}, 32'h0);
        check("mid_rst_addr",  bus1.imem_addr, 32'h0);
        rst = 1'b0;

        // Out-of-range redirect to IMEM_BYTES
        step();
        step();
        redirect(32'h80);
        check("oor_fault", {31'h0, bus1.fault}, 32'h1);
        check("oor_valid", {31'h0, bus1.out_valid}, 32'h0);
        check("oor_addr",  bus1.imem_addr, 32'h08);

        // Sequential overrun on the non-zero-halt-word instance
        reset_and_release(1'b1);
        for (int i = 0; i < 32; i++) step();
        check("ovr_fault_before", {31'h0, bus2.fault}, 32'h0);
        check("ovr_last_pc",      bus2.out_pc, 32'h7C);
        check("ovr_last_instr",   bus2.out_instr, 32'h0);
        step();
        check("ovr_fault",    {31'h0, bus2.fault}, 32'h1);
        check("ovr_valid",    {31'h0, bus2.out_valid}, 32'h0);
        check("ovr_pops",     32'(pops2), 32'd32);
        check("ovr_mon_last", last_pc2, 32'h7C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the lab CPU.
- Owns the PC and drives the combinational-read instruction memory (byte-addressed, 128 bytes, little-endian words).
- Buffers fetched {pc, instr} pairs in a 2-entry FIFO towards decode with a valid/ready handshake.
- Handles branch/jump redirects, stops on the all-zero padding word (halt), and flags out-of-range or misaligned fetches (fault).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_BYTES, 128, instruction memory size in bytes; legal fetch PCs are 0..IMEM_BYTES-4, word-aligned.
- HALT_WORD, 32'h0000_0000, instruction value that terminates fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals fetch_pc combinationally.
- imem_rdata  in  32  instruction word at imem_addr, valid in the same cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target PC, sampled when redirect_valid=1.
- out_valid  out  1  FIFO head holds a valid entry.
- out_ready  in  1  decode accepts the head entry this cycle.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- halted  out  1  HALT_WORD fetched and FIFO drained; sticky.
- fault  out  1  illegal fetch or redirect address; sticky until rst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - fetch_pc=RESET_PC, FIFO empty, state=RUN.
  - out_valid=0, out_pc=0, out_instr=0, halted=0, fault=0.
  - Reset mid-operation discards FIFO contents and pending state.
- States:
  - RUN: fetching.
  - STOP: HALT_WORD seen; drain the FIFO.
  - HALT: halted=1.
  - FAULT: fault=1, no fetch.
- Pop: occurs when out_valid && out_ready.
- Push (RUN only): a push occurs when all of the following hold:
  - imem_rdata != HALT_WORD,
  - fetch_pc is legal,
  - no redirect this cycle,
  - count<2, or count==2 with a pop this cycle.
  - On push, {fetch_pc, imem_rdata} is written and fetch_pc += 4.
  - Simultaneous push and pop at count==2 keeps count=2.
- Latency and throughput:
  - An entry is visible on out_* the cycle after its push.
  - Sustained throughput is 1 instr/cycle with out_ready held at 1.
  - First out_valid is the 1st cycle after rst deasserts.
- Halt word in RUN (imem_rdata==HALT_WORD, legal PC, no redirect):
  - No push; fetch_pc holds; go to STOP.
  - STOP→HALT when the FIFO is empty; halted rises that edge.
  - Entries already buffered are still delivered.
- Sequential overrun in RUN: fetch_pc > IMEM_BYTES-4 → no push, go to FAULT.
- Redirect:
  - Highest priority; accepted in RUN, STOP and HALT.
  - FIFO is flushed (out_valid=0 next cycle) and no push occurs that cycle.
  - If redirect_pc[1:0]==0 and redirect_pc <= IMEM_BYTES-4: fetch_pc=redirect_pc, state=RUN, halted=0.
  - Otherwise: state=FAULT, fetch_pc unchanged.
- FAULT: absorbing. Redirects are ignored, out_valid=0, only rst exits.
- Ordering: out_pc/out_instr stay stable while out_valid=1 and out_ready=0.
- Width: PC arithmetic is 32-bit unsigned; the +4 wrap beyond 2^32 is unreachable given the legality check.

Decomposition:
- Package fetch_pkg:
  - State enum {RUN, STOP, HALT, FAULT}.
  - Constants RESET_PC, IMEM_BYTES, HALT_WORD.
  - Legality function: aligned and in range.
- One sub-module fetch_fifo: 2-entry, 64-bit-wide synchronous FIFO.
  - Ports: push, pop, flush, full, empty, count, and head data.
  - flush has priority over push/pop.
- fetch_ctrl holds the PC register, the FSM and the redirect logic.

Test Plan:
- Lab-2 program loaded, out_ready=1, release rst → cycles 1..18 show out_pc 0x00..0x44 with out_instr 0xff600293, 0x00528333, ... 0x007383b3; fetch of 0x48 reads 0 → halted=1 exactly one cycle after the 0x44 entry pops; fault=0.
- out_ready=0 for 5 cycles after reset → out_valid=1, out_pc stays 0x00 with instr 0xff600293; FIFO holds 0x00 and 0x04; imem_addr parks at 0x08; on release the order is 0x00, 0x04, 0x08 with no gaps or duplicates.
- redirect_valid=1, redirect_pc=0x20 while FIFO is full → next cycle out_valid=0; following cycle out_pc=0x20, out_instr=0x00030eb3, then 0x24 (0x01d31463).
- After halted=1, redirect to 0x2C → halted clears; entries 0x2C (0x000003b3) through 0x44 are delivered; halts again.
- Redirect to 0x22 (misaligned) → fault=1 next cycle, out_valid=0; subsequent redirect to 0x00 is ignored; only rst clears fault.
- Redirect to 0x80 (IMEM_BYTES) → fault=1; separately, HALT_WORD=0xFFFFFFFF with zero padding → sequential fetch reaches 0x80 → fault=1 after the 0x7C entry is pushed.
